// File: rtl/spi_regs_pkg.sv
// rtl/spi_regs_pkg.sv - shared register map, frame size and FSM state type for spi_peripheral
package spi_regs_pkg;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  localparam int FRAME_BITS = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } spi_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - multi-flop synchroniser with history flop and edge detection
// Ports:
//   clk      system clock
//   rst_n    synchronous active-low reset; all flops load RESET_VAL
//   async_in asynchronous pin
//   level    synchronised level
//   rise     one-cycle pulse on a synchronised 0->1 transition
//   fall     one-cycle pulse on a synchronised 1->0 transition
module sync_edge_det #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_peripheral.sv
// rtl/spi_peripheral.sv - SPI mode-0 write-only register file feeding the PWM stage
// Ports:
//   clk, rst_n          system clock, synchronous active-low reset
//   sclk, ncs, copi     asynchronous SPI pins (sclk is sampled, never used as a clock)
//   en_reg_out_7_0      reg 0x00, en_reg_out_15_8 reg 0x01
//   en_reg_pwm_7_0      reg 0x02, en_reg_pwm_15_8 reg 0x03
//   pwm_duty_cycle      reg 0x04
module spi_peripheral
  import spi_regs_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       ncs,
  input  logic       copi,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle
);

  localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);
  localparam logic [4:0] CNT_SAT  = 5'(FRAME_BITS + 1);

  logic sclk_level, sclk_rise, sclk_fall;
  logic ncs_level, ncs_rise, ncs_fall;
  logic copi_level, copi_rise, copi_fall;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .async_in(sclk),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .async_in(ncs),
    .level(ncs_level), .rise(ncs_rise), .fall(ncs_fall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .async_in(copi),
    .level(copi_level), .rise(copi_rise), .fall(copi_fall)
  );

  // Mode 0 needs only the sampling edge; the remaining detector outputs are unused.
  logic unused_edges;
  assign unused_edges = &{1'b0, sclk_level, sclk_fall, copi_rise, copi_fall};

  spi_state_e            state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q;
  logic [4:0]            cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ncs_fall) state_d = SHIFT;
      SHIFT:   if (ncs_rise) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic shift_en;
  assign shift_en = (state_q == SHIFT) && sclk_rise && !ncs_level;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (state_q == IDLE && ncs_fall) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (shift_en) begin
      shift_q <= {shift_q[FRAME_BITS-2:0], copi_level};
      // Saturating at 17 keeps any overlong frame distinguishable from an exact one.
      if (cnt_q != CNT_SAT) cnt_q <= cnt_q + 5'd1;
    end
  end

  logic       frame_rw;
  logic [6:0] frame_addr;
  logic [7:0] frame_data;
  logic       commit_ok;

  assign frame_rw   = shift_q[15];
  assign frame_addr = shift_q[14:8];
  assign frame_data = shift_q[7:0];
  assign commit_ok  = (state_q == COMMIT) && (cnt_q == CNT_FULL) && frame_rw &&
                      (frame_addr <= MAX_ADDR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_reg_out_7_0  <= 8'h00;
      en_reg_out_15_8 <= 8'h00;
      en_reg_pwm_7_0  <= 8'h00;
      en_reg_pwm_15_8 <= 8'h00;
      pwm_duty_cycle  <= 8'h00;
    end else if (commit_ok) begin
      case (frame_addr)
        ADDR_EN_OUT_LO: en_reg_out_7_0  <= frame_data;
        ADDR_EN_OUT_HI: en_reg_out_15_8 <= frame_data;
        ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= frame_data;
        ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= frame_data;
        ADDR_DUTY:      pwm_duty_cycle  <= frame_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_peripheral.sv
// tb/tb_spi_peripheral.sv - scoreboard testbench for spi_peripheral
module tb_spi_peripheral;

  localparam int HALF = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic ncs = 1'b1;
  logic copi = 1'b0;

  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic [39:0] outs;

  always #5 clk = ~clk;

  spi_peripheral dut (
    .clk(clk),
    .rst_n(rst_n),
    .sclk(sclk),
    .ncs(ncs),
    .copi(copi),
    .en_reg_out_7_0(en_reg_out_7_0),
    .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0),
    .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle)
  );

  assign outs = {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle};

  int n_checks = 0;
  int n_fail = 0;
  logic [39:0] exp_q[$];
  logic [7:0] model[5];
  bit mon_en = 1'b0;

  function automatic logic [39:0] model_vec();
    return {model[0], model[1], model[2], model[3], model[4]};
  endfunction

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      copi = v[i];
      clks(HALF);
      sclk = 1'b1;
      clks(HALF);
      sclk = 1'b0;
    end
  endtask

  // Full frame; the expected register image is queued before ncs rises.
  task automatic send(input logic [31:0] v, input int n, input int gap);
    ncs = 1'b0;
    clks(HALF);
    shift_bits(v, n);
    clks(HALF);
    if (n == 16 && v[15] && v[14:8] <= 7'h04) begin
      model[int'(v[14:8])] = v[7:0];
      exp_q.push_back(model_vec());
    end
    ncs = 1'b1;
    clks(gap);
  endtask

  // Monitor: every change on the register outputs must match the next queued image.
  initial begin
    logic [39:0] prev;
    wait (mon_en);
    prev = outs;
    forever begin
      @(negedge clk);
      if (outs !== prev) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_change: got %h expected %h", outs, prev);
        end else begin
          check("scoreboard", outs, exp_q.pop_front());
        end
        prev = outs;
      end
    end
  end

  logic [31:0] rej_v[4];
  int          rej_n[4];

  initial begin
    rej_v = '{32'h0000_0411, 32'h0000_8511, 32'h0000_4211, 32'h0001_08AB};
    rej_n = '{16, 16, 15, 17};
    for (int i = 0; i < 5; i++) model[i] = 8'h00;

    // Reset with pins toggling
    for (int i = 0; i < 5; i++) begin
      sclk = ~sclk;
      ncs = ~ncs;
      clks(1);
    end
    sclk = 1'b0;
    ncs = 1'b1;
    clks(3);
    check("reset_outs", outs, 40'h0);
    rst_n = 1'b1;
    clks(10);
    check("idle_after_reset", outs, 40'h0);
    mon_en = 1'b1;
    clks(2);

    // Valid write with exact latency from ncs rising
    ncs = 1'b0;
    clks(HALF);
    shift_bits(32'h8480, 16);
    clks(HALF);
    model[4] = 8'h80;
    exp_q.push_back(model_vec());
    ncs = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("latency_edge3", {32'h0, pwm_duty_cycle}, 40'h00);
    @(posedge clk);
    #1 check("latency_edge4", {32'h0, pwm_duty_cycle}, 40'h80);
    clks(12);
    check("only_duty_written", outs, 40'h00_00_00_00_80);

    // All registers
    send(32'h80FF, 16, 12);
    send(32'h81FF, 16, 12);
    send(32'h82FF, 16, 12);
    send(32'h83A5, 16, 12);
    send(32'h8440, 16, 12);
    check("all_regs", outs, 40'hFF_FF_FF_A5_40);

    // Rejected frames with duty at 0x80
    send(32'h8480, 16, 12);
    for (int i = 0; i < 4; i++) begin
      send(rej_v[i], rej_n[i], 12);
      check($sformatf("rejected_%0d", i), outs, 40'hFF_FF_FF_A5_80);
    end

    // Reset in the middle of a frame
    for (int i = 0; i < 5; i++) model[i] = 8'h00;
    exp_q.push_back(model_vec());
    ncs = 1'b0;
    clks(HALF);
    shift_bits(32'h813C >> 6, 10);
    rst_n = 1'b0;
    clks(3);
    ncs = 1'b1;
    sclk = 1'b0;
    clks(2);
    rst_n = 1'b1;
    clks(10);
    check("abandoned_frame", {32'h0, en_reg_out_15_8}, 40'h00);
    send(32'h813C, 16, 12);
    check("after_reset_frame", {32'h0, en_reg_out_15_8}, 40'h3C);

    // Back-to-back frames, ncs high for one sclk period between them
    send(32'h820F, 16, 2 * HALF);
    send(32'h83F0, 16, 12);
    check("back_to_back", outs, 40'h00_3C_0F_F0_00);

    clks(10);
    check("scoreboard_drained", 40'(exp_q.size()), 40'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
